fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage: owns the PC, issues one word fetch at a time to instruction memory,
//  and holds the returned instruction plus its PC in an output register for the decode/imm-gen
//  stage over a valid/ready handshake. Redirects (branch/jump/JALR target from execute) flush
//  the held instruction and drop any in-flight response. Sits between imem and decode.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded on reset; bits[1:0] must be 0
// PORTS
//  clk           in   1   clock, rising edge
//  n_rst         in   1   synchronous active-low reset
//  imem_req      out  1   fetch request valid
//  imem_addr     out  32  fetch byte address (word aligned)
//  imem_gnt      in   1   imem accepts request this cycle (imem_req & imem_gnt = accepted)
//  imem_rvalid   in   1   read data valid (>=1 cycle after accept)
//  imem_rdata    in   32  instruction word
//  redirect      in   1   flush + load new PC
//  redirect_pc   in   32  new PC; bits[1:0] forced to 0
//  id_valid      out  1   id_instr/id_pc valid to decode
//  id_ready      in   1   decode accepts (id_valid & id_ready = handshake)
//  id_instr      out  32  instruction to decode/immediate generator
//  id_pc         out  32  PC of id_instr
//  id_pc_plus4   out  32  id_pc + 4 (JAL/JALR link value), mod 2^32
// BEHAVIOUR
//  - Reset (n_rst=0 at posedge): pc<=RESET_PC, state<=REQ, id_valid<=0, id_instr/id_pc<=0;
//    imem_req=0 while n_rst=0. Reset mid-operation abandons any outstanding fetch.
//  - States: REQ, WAIT, HOLD, DRAIN. Single outstanding request; never two in flight.
//  - REQ: imem_req=1, imem_addr=pc (registered PC). gnt -> WAIT; else stay REQ.
//  - WAIT: imem_req=0. rvalid -> id_instr<=rdata, id_pc<=pc, id_valid<=1, pc<=pc+4, -> HOLD.
//  - HOLD: imem_req=0, outputs stable. id_ready -> id_valid<=0, -> REQ.
//  - DRAIN: imem_req=0; rvalid -> data discarded, -> REQ.
//  - rvalid in REQ or HOLD is ignored (stale response after reset).
//  - Redirect (priority over all above, any state): pc<=redirect_pc & ~3, id_valid<=0, then:
//    REQ no gnt -> REQ (new addr next cycle); REQ with gnt same cycle -> DRAIN;
//    WAIT no rvalid -> DRAIN; WAIT with rvalid same cycle -> REQ (response dropped);
//    HOLD -> REQ; DRAIN no rvalid -> DRAIN; DRAIN with rvalid -> REQ.
//  - Redirect and id handshake in same HOLD cycle: handshake counts as completed; PC from redirect.
//  - Latency: accept-to-id_valid = 1 cycle after rvalid; min 3 cycles/instr (REQ,WAIT,HOLD) with
//    gnt same cycle, rvalid next cycle, id_ready high.
//  - PC arithmetic 32-bit, wraps: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
//  - imem_req, once high without gnt, stays high with constant addr unless redirect or reset.
// CONFIGURATION
//  FETCH_CNT_EN defined: extra port fetch_count out 32 = number of completed id handshakes;
//    reset 0, +1 per id_valid&id_ready cycle, wraps at 2^32, not cleared by redirect.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset release, RESET_PC=0: first cycle n_rst=1 -> imem_req=1, imem_addr=0; during reset imem_req=0.
//  2 gnt immediate, rvalid next cycle rdata=32'h0050_0093, id_ready=1 -> id_valid=1, id_instr=32'h0050_0093,
//    id_pc=0, id_pc_plus4=4; next imem_addr=4.
//  3 id_ready=0 for 3 cycles in HOLD -> id_instr/id_pc stable, id_valid=1, imem_req=0 throughout.
//  4 Redirect to 32'h0000_0103 during WAIT, later rvalid rdata=32'hDEAD_BEEF -> id_valid stays 0,
//    next imem_addr=32'h0000_0100.
//  5 Redirect while imem_req=1 and imem_gnt=0 -> imem_addr changes to redirect_pc next cycle, no DRAIN.
//  6 pc=32'hFFFF_FFFC fetch completes -> next imem_addr=0; with FETCH_CNT_EN fetch_count increments by 1.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word fetches to imem and
// holds the returned instruction for decode. Optional FETCH_CNT_EN adds a handshake counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        accept;

  // Request is gated by reset so it is low before the first reset edge settles the state.
  assign imem_req    = n_rst && (state == REQ);
  assign imem_addr   = pc;
  assign accept      = imem_req && imem_gnt;
  assign id_pc_plus4 = id_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= REQ;
      pc       <= RESET_PC;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else if (redirect) begin
      // Redirect wins; an accepted-but-unreturned fetch must be drained before re-issuing.
      pc       <= redirect_pc & ~32'd3;
      id_valid <= 1'b0;
      unique case (state)
        REQ:     state <= accept ? DRAIN : REQ;
        WAIT:    state <= imem_rvalid ? REQ : DRAIN;
        HOLD:    state <= REQ;
        DRAIN:   state <= imem_rvalid ? REQ : DRAIN;
        default: state <= REQ;
      endcase
    end else begin
      unique case (state)
        REQ: if (accept) state <= WAIT;
        WAIT: if (imem_rvalid) begin
          id_instr <= imem_rdata;
          id_pc    <= pc;
          id_valid <= 1'b1;
          pc       <= pc + 32'd4;
          state    <= HOLD;
        end
        HOLD: if (id_ready) begin
          id_valid <= 1'b0;
          state    <= REQ;
        end
        DRAIN: if (imem_rvalid) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end

`ifdef FETCH_CNT_EN
  // Counts decode handshakes, including one that coincides with a redirect.
  always_ff @(posedge clk) begin
    if (!n_rst)                    fetch_count <= '0;
    else if (id_valid && id_ready) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule
